wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf_if.sv | 27 ++
 rtl/wb_grf.sv | 130 +++++++++++++
 tb/tb_wb_grf.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_grf_if.sv
// Bus between the pipeline and the general register file: W-stage retire inputs,
// D-stage read ports and the write-back/forwarding outputs.
interface wb_grf_if;
  logic [31:0] instr_W;
  logic [31:0] PC_W;
  logic [31:0] ALU_W;
  logic [31:0] DM_W;
  logic [31:0] MDU_W;
  logic [4:0]  rs_addr_D;
  logic [4:0]  rt_addr_D;
  logic [31:0] rs_data_D;
  logic [31:0] rt_data_D;
  logic        wb_we_W;
  logic [4:0]  wb_addr_W;
  logic [31:0] wb_data_W;
  logic [31:0] retired_cnt;

  modport master (
    output instr_W, PC_W, ALU_W, DM_W, MDU_W, rs_addr_D, rt_addr_D,
    input  rs_data_D, rt_data_D, wb_we_W, wb_addr_W, wb_data_W, retired_cnt
  );

  modport slave (
    input  instr_W, PC_W, ALU_W, DM_W, MDU_W, rs_addr_D, rt_addr_D,
    output rs_data_D, rt_data_D, wb_we_W, wb_addr_W, wb_data_W, retired_cnt
  );
endinterface

// File: rtl/wb_grf.sv
// W-stage write-back decode, load extension and 32x32 register file with a retire counter.
// Define GRF_BYPASS_EN to forward the same-cycle write-back value onto the D-stage read ports.
module wb_grf (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [4:0]  dst_addr;
  logic        sel_load;
  logic        sel_mdu;
  logic        sel_jal;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        wb_we;

  logic [31:0] regs_reg [32];
  logic [31:0] retired_cnt_reg;

  assign opcode   = bus.instr_W[31:26];
  assign funct    = bus.instr_W[5:0];
  assign rt_field = bus.instr_W[20:16];
  assign rd_field = bus.instr_W[15:11];

  // Destination decode; anything not listed (jr, mult/div, mthi/mtlo, branches,
  // stores, bubbles, unknown codes) leaves dst_addr at 0, which means no write.
  always_comb begin
    dst_addr = 5'd0;
    sel_load = 1'b0;
    sel_mdu  = 1'b0;
    sel_jal  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B: dst_addr = rd_field;
          6'h10, 6'h12: begin
            dst_addr = rd_field;
            sel_mdu  = 1'b1;
          end
          default: dst_addr = 5'd0;
        endcase
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: dst_addr = rt_field;
      6'h20, 6'h21, 6'h23: begin
        dst_addr = rt_field;
        sel_load = 1'b1;
      end
      6'h03: begin
        dst_addr = 5'd31;
        sel_jal  = 1'b1;
      end
      default: dst_addr = 5'd0;
    endcase
  end

  // Load extension: DM_W is the raw aligned word, the low address bits pick the lane.
  always_comb begin
    half_sel = bus.ALU_W[1] ? bus.DM_W[31:16] : bus.DM_W[15:0];
    case (bus.ALU_W[1:0])
      2'd0:    byte_sel = bus.DM_W[7:0];
      2'd1:    byte_sel = bus.DM_W[15:8];
      2'd2:    byte_sel = bus.DM_W[23:16];
      default: byte_sel = bus.DM_W[31:24];
    endcase
    case (opcode)
      6'h20:   load_data = {{24{byte_sel[7]}}, byte_sel};
      6'h21:   load_data = {{16{half_sel[15]}}, half_sel};
      default: load_data = bus.DM_W;
    endcase
  end

  assign wb_data = sel_load ? load_data :
                   sel_mdu  ? bus.MDU_W :
                   sel_jal  ? bus.PC_W + 32'd8 :
                              bus.ALU_W;
  assign wb_we   = (dst_addr != 5'd0);

  assign bus.wb_we_W     = wb_we;
  assign bus.wb_addr_W   = dst_addr;
  assign bus.wb_data_W   = wb_data;
  assign bus.retired_cnt = retired_cnt_reg;

  // Reset wins over any write presented in the same cycle; $0 is never targeted
  // because wb_we excludes address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= 32'd0;
      end
    end else if (wb_we) begin
      regs_reg[dst_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_reg <= 32'd0;
    end else if (bus.instr_W != 32'd0) begin
      retired_cnt_reg <= retired_cnt_reg + 32'd1;
    end
  end

  logic [4:0]  rd_addr [2];
  logic [31:0] rd_data [2];

  assign rd_addr[0]    = bus.rs_addr_D;
  assign rd_addr[1]    = bus.rt_addr_D;
  assign bus.rs_data_D = rd_data[0];
  assign bus.rt_data_D = rd_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [31:0] stored;
      assign stored = (rd_addr[gi] == 5'd0) ? 32'd0 : regs_reg[rd_addr[gi]];
`ifdef GRF_BYPASS_EN
      assign rd_data[gi] = (wb_we && (rd_addr[gi] == dst_addr)) ? wb_data : stored;
`else
      assign rd_data[gi] = stored;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: stimulus queues expected values, a negedge monitor
// pops and compares them against the live DUT outputs.
module tb_wb_grf;

  localparam int SEL_WE   = 0;
  localparam int SEL_ADDR = 1;
  localparam int SEL_DATA = 2;
  localparam int SEL_RS   = 3;
  localparam int SEL_RT   = 4;
  localparam int SEL_CNT  = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [31:0] exp_cnt;
  exp_t sb_q[$];

  wb_grf_if bus();

  wb_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_WE:   return {31'd0, bus.wb_we_W};
      SEL_ADDR: return {27'd0, bus.wb_addr_W};
      SEL_DATA: return bus.wb_data_W;
      SEL_RS:   return bus.rs_data_D;
      SEL_RT:   return bus.rt_data_D;
      default:  return bus.retired_cnt;
    endcase
  endfunction

  // Monitor: every falling edge, compare all pending expectations.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      act = observe(e.sel);
      tests_run++;
      if (act !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end else begin
        $display("[TB] ok %s = 0x%08h", e.name, act);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_wb(input string name, input logic we, input logic [4:0] addr,
                           input logic [31:0] data);
    expect_val({name, ".we"}, SEL_WE, {31'd0, we});
    expect_val({name, ".addr"}, SEL_ADDR, {27'd0, addr});
    if (we) expect_val({name, ".data"}, SEL_DATA, data);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] mdu);
    bus.instr_W = instr;
    bus.PC_W    = pc;
    bus.ALU_W   = alu;
    bus.DM_W    = dm;
    bus.MDU_W   = mdu;
  endtask

  // Advance one cycle; a non-bubble instruction on the bus retires at this edge.
  task automatic tick();
    if (!reset && bus.instr_W != 32'd0) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] byte_exp [4];
    byte_exp[0] = 32'h0000_0001;
    byte_exp[1] = 32'h0000_007F;
    byte_exp[2] = 32'hFFFF_FFFF;
    byte_exp[3] = 32'hFFFF_FF80;

    reset = 1'b1;
    bus.rs_addr_D = 5'd0;
    bus.rt_addr_D = 5'd0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_cnt = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    bus.rs_addr_D = 5'd1;
    bus.rt_addr_D = 5'd31;
    expect_val("reset.cnt", SEL_CNT, 32'd0);
    expect_val("reset.rs1", SEL_RS, 32'd0);
    expect_val("reset.rt31", SEL_RT, 32'd0);
    expect_wb("reset.bubble", 1'b0, 5'd0, 32'd0);
    tick();

    // ori $1,$0,0x1234
    drive(32'h3401_1234, 32'h0000_3000, 32'h0000_1234, 32'd0, 32'd0);
    expect_wb("ori1", 1'b1, 5'd1, 32'h0000_1234);
    expect_val("ori1.cnt_before", SEL_CNT, 32'd0);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.rs_addr_D = 5'd1;
    expect_val("ori1.read", SEL_RS, 32'h0000_1234);
    expect_val("ori1.cnt", SEL_CNT, 32'd1);
    tick();

    // jal
    drive(32'h0C00_0000, 32'h0000_3000, 32'hDEAD_0000, 32'd0, 32'd0);
    expect_wb("jal", 1'b1, 5'd31, 32'h0000_3008);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.rt_addr_D = 5'd31;
    expect_val("jal.read31", SEL_RT, 32'h0000_3008);
    expect_val("jal.cnt", SEL_CNT, 32'd2);
    tick();

    // lb $2 across all four byte lanes
    for (int i = 0; i < 4; i++) begin
      drive(32'h8002_0000, 32'd0, 32'h0000_1000 | i, 32'h80FF_7F01, 32'd0);
      expect_wb($sformatf("lb_lane%0d", i), 1'b1, 5'd2, byte_exp[i]);
      tick();
    end
    // lh $2 upper half, then lw $2
    drive(32'h8402_0000, 32'd0, 32'h0000_1002, 32'h80FF_7F01, 32'd0);
    expect_wb("lh_hi", 1'b1, 5'd2, 32'hFFFF_80FF);
    tick();
    drive(32'h8402_0000, 32'd0, 32'h0000_1000, 32'h80FF_7F01, 32'd0);
    expect_wb("lh_lo", 1'b1, 5'd2, 32'h0000_7F01);
    tick();
    drive(32'h8C02_0000, 32'd0, 32'h0000_1000, 32'h80FF_7F01, 32'd0);
    expect_wb("lw", 1'b1, 5'd2, 32'h80FF_7F01);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.rs_addr_D = 5'd2;
    expect_val("lw.read2", SEL_RS, 32'h80FF_7F01);
    expect_val("loads.cnt", SEL_CNT, 32'd9);
    tick();

    // add $3,$1,$2 and mfhi $4
    drive(32'h0022_1820, 32'd0, 32'h0000_DEAD, 32'h1111_1111, 32'h2222_2222);
    expect_wb("add3", 1'b1, 5'd3, 32'h0000_DEAD);
    tick();
    drive(32'h0000_2010, 32'd0, 32'h0000_BEEF, 32'h1111_1111, 32'hCAFE_F00D);
    expect_wb("mfhi4", 1'b1, 5'd4, 32'hCAFE_F00D);
    tick();

    // ori $0 must not write; $0 still reads 0
    drive(32'h3400_1111, 32'd0, 32'h0000_1111, 32'd0, 32'd0);
    expect_wb("ori0", 1'b0, 5'd0, 32'd0);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.rs_addr_D = 5'd0;
    bus.rt_addr_D = 5'd3;
    expect_val("r0.read", SEL_RS, 32'd0);
    expect_val("add3.read", SEL_RT, 32'h0000_DEAD);
    expect_val("ori0.cnt", SEL_CNT, exp_cnt);
    tick();

    // jr and mult: no write, but both retire
    drive(32'h03E0_0008, 32'd0, 32'h1234_5678, 32'd0, 32'd0);
    expect_wb("jr", 1'b0, 5'd0, 32'd0);
    tick();
    drive(32'h0022_0018, 32'd0, 32'h1234_5678, 32'd0, 32'd0);
    expect_wb("mult", 1'b0, 5'd0, 32'd0);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("jr_mult.cnt", SEL_CNT, exp_cnt);
    tick();
    expect_val("bubble.cnt_unchanged", SEL_CNT, exp_cnt);
    tick();

    // Same-cycle write $5 and read $5
    drive(32'h2005_A5A5, 32'd0, 32'hA5A5_A5A5, 32'd0, 32'd0);
    bus.rs_addr_D = 5'd5;
`ifdef GRF_BYPASS_EN
    expect_val("same_cycle.rs5", SEL_RS, 32'hA5A5_A5A5);
`else
    expect_val("same_cycle.rs5", SEL_RS, 32'd0);
`endif
    expect_wb("addi5", 1'b1, 5'd5, 32'hA5A5_A5A5);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("next_cycle.rs5", SEL_RS, 32'hA5A5_A5A5);
    tick();

    // Counter wrap
    dut.retired_cnt_reg = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    drive(32'h0022_0018, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("wrap.before", SEL_CNT, 32'hFFFF_FFFF);
    tick();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("wrap.after", SEL_CNT, 32'd0);
    tick();

    // Reset while a write to $3 and a retiring instruction are presented
    drive(32'h0022_0018, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    drive(32'h0022_1820, 32'd0, 32'h0000_1111, 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 32'd0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.rs_addr_D = 5'd1;
    bus.rt_addr_D = 5'd3;
    expect_val("rst_mid.rt3", SEL_RT, 32'd0);
    expect_val("rst_mid.rs1", SEL_RS, 32'd0);
    expect_val("rst_mid.cnt", SEL_CNT, 32'd0);
    tick();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
